approx_ctrl: RTL and testbench
==============================

Name: approx_ctrl

Overview:
- Sequencing controller for the fixed-point approximation datapath (Q1.14, 1.0 = 16384).
- Accepts one operand and normalises it into [0.75, 1.5] by iterative single-bit shifts, one shift per clock.
- Hands the normalised value to the approximation core, waits for its result, then applies the inverse (reciprocal-style) post-shift.
- Sits between the requesting top-level FSM and the approximation core.

Parameters:
- W, 16, operand/result bit width (signed).
- UPPER_BOUND, 24576, normalisation upper limit (1.5 in Q1.14).
- LOWER_BOUND, 12288, normalisation lower limit (0.75 in Q1.14).
- MAX_SHIFT, 7, maximum shifts in either direction; counters are 3 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- x_i  in  W  signed operand; captured when start_i is accepted.
- busy_o  out  1  high in every state except IDLE.
- core_x_o  out  W  normalised operand to the core; held stable from core_start_o until core_done_i.
- core_start_o  out  1  one-cycle start pulse to the core.
- core_result_i  in  W  signed core result; valid with core_done_i.
- core_done_i  in  1  core completion pulse.
- result_o  out  W  post-shifted result; held until the next accepted start.
- shift_l_o  out  3  left shifts applied during normalisation.
- shift_r_o  out  3  right shifts applied during normalisation.
- err_o  out  1  operand invalid or not normalisable; valid with done_o.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; all outputs 0, including result_o, core_x_o, shift counters and err_o. Reset in any state aborts the operation. core_start_o is never asserted in the reset cycle. A core_done_i arriving after reset is ignored.
- States: IDLE, SCALE, CORE_START, CORE_WAIT, POST, DONE.
- IDLE
  - start_i=1: capture x_i into x_reg, clear shift_l_o, shift_r_o and err_o, go to SCALE.
  - start_i=0: stay.
- SCALE, one decision per cycle on x_reg:
  - x_reg <= 0: set err_o, go to POST. No core start; result forced to 0.
  - x_reg > UPPER_BOUND: x_reg <= x_reg >>> 1, shift_r_o + 1.
  - x_reg < LOWER_BOUND: x_reg <= x_reg << 1, shift_l_o + 1.
  - Otherwise (in range, bounds inclusive): core_x_o <= x_reg, go to CORE_START.
  - A required shift when the relevant counter already equals MAX_SHIFT: no shift, set err_o, go to POST.
- CORE_START: core_start_o=1 for exactly this cycle, go to CORE_WAIT.
- CORE_WAIT
  - Wait indefinitely for core_done_i; no timeout.
  - On core_done_i, latch core_result_i and go to POST.
  - core_done_i in any other state is ignored.
- POST
  - Compute in W+MAX_SHIFT bits: core result << shift_l_o, or >>> shift_r_o (arithmetic).
  - Both counters non-zero cannot occur with these bounds; if it does, left is applied then right.
  - Register the value truncated or saturated to W bits into result_o; result_o=0 when err_o.
  - Go to DONE.
- DONE: done_o=1 for exactly this cycle, go to IDLE. start_i in DONE is ignored; the requester must reassert it in IDLE.
- busy_o is combinational from state.
- Latency from the start_i edge to done_o high, for n normalisation shifts and a core responding c cycles after core_start_o: n + c + 5 cycles.
- start_i while busy_o=1 is ignored and does not queue.

Optional Feature:
- Macro APPROX_CTRL_SAT_EN.
- Defined: POST saturates the wide value to [-2^(W-1), 2^(W-1)-1], i.e. 32767/-32768 for W=16.
- Undefined: POST keeps the low W bits (wrap).

Test Plan:
- x_i=16384, core returns 16384 after 1 cycle: no shifts, core_x_o=16384, result_o=16384, shift_l_o=shift_r_o=0, err_o=0, done_o 6 cycles after start.
- x_i=32000, core returns 16768: one right shift, core_x_o=16000, shift_r_o=1, result_o=8384.
- x_i=8192, core returns 16384: shift_l_o=1, core_x_o=16384; raw result 32768 gives result_o=32767 with APPROX_CTRL_SAT_EN and -32768 without.
- x_i=0 and x_i=-5: no core_start_o, err_o=1, result_o=0, done_o pulses. x_i=1: 7 left shifts give 128 < 12288, so err_o=1 with shift_l_o=7.
- Core delays core_done_i 20 cycles, start_i held high throughout: busy_o stays 1, no second core_start_o, exactly one done_o.
- rst asserted in CORE_WAIT, then a late core_done_i: state IDLE, all outputs 0, no done_o; the next start with x_i=16384 completes normally.

Source files
------------

// File: rtl/approx_ctrl.sv
// approx_ctrl: normalise operand, run approximation core, post-shift result (optional saturation: APPROX_CTRL_SAT_EN)
module approx_ctrl #(
  parameter int W           = 16,
  parameter int UPPER_BOUND = 24576,
  parameter int LOWER_BOUND = 12288,
  parameter int MAX_SHIFT   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] x_i,
  output logic         busy_o,
  output logic [W-1:0] core_x_o,
  output logic         core_start_o,
  input  logic [W-1:0] core_result_i,
  input  logic         core_done_i,
  output logic [W-1:0] result_o,
  output logic [2:0]   shift_l_o,
  output logic [2:0]   shift_r_o,
  output logic         err_o,
  output logic         done_o
);
  localparam int WW = W + MAX_SHIFT;
  localparam logic signed [W-1:0] UB = W'(UPPER_BOUND);
  localparam logic signed [W-1:0] LB = W'(LOWER_BOUND);
  localparam logic [2:0] MS = 3'(MAX_SHIFT);
  typedef enum logic [2:0] {IDLE, SCALE, CORE_START, CORE_WAIT, POST, DONE} state_t;
  state_t state_q, state_d;
  logic signed [W-1:0] x_q, x_d, cr_q, cr_d;
  logic [W-1:0] cx_q, cx_d, res_q, res_d, post;
  logic [2:0] sl_q, sl_d, sr_q, sr_d;
  logic err_q, err_d, cs_q, done_q;
  logic signed [WW-1:0] wide_l, wide;
  logic need_r, need_l;
  assign need_r = x_q > UB;
  assign need_l = x_q < LB;
  assign wide_l = $signed({{MAX_SHIFT{cr_q[W-1]}}, cr_q}) <<< sl_q;
  assign wide = wide_l >>> sr_q;
`ifdef APPROX_CTRL_SAT_EN
  localparam logic signed [WW-1:0] HI = WW'(2**(W-1) - 1);
  localparam logic signed [WW-1:0] LO = WW'(-(2**(W-1)));
  assign post = wide > HI ? {1'b0, {(W-1){1'b1}}} : wide < LO ? {1'b1, {(W-1){1'b0}}} : wide[W-1:0];
`else
  assign post = wide[W-1:0];
`endif
  // next-state and datapath updates, one normalisation decision per SCALE cycle
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    cx_d = cx_q;
    cr_d = cr_q;
    res_d = res_q;
    sl_d = sl_q;
    sr_d = sr_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        x_d = x_i;
        sl_d = '0;
        sr_d = '0;
        err_d = 1'b0;
        state_d = SCALE;
      end
      SCALE: if (x_q[W-1] || x_q == '0 || (need_r && sr_q == MS) || (need_l && sl_q == MS)) begin
        err_d = 1'b1;
        state_d = POST;
      end else if (need_r) begin
        x_d = x_q >>> 1;
        sr_d = sr_q + 3'd1;
      end else if (need_l) begin
        x_d = x_q <<< 1;
        sl_d = sl_q + 3'd1;
      end else begin
        cx_d = x_q;
        state_d = CORE_START;
      end
      CORE_START: state_d = CORE_WAIT;
      CORE_WAIT: if (core_done_i) begin
        cr_d = core_result_i;
        state_d = POST;
      end
      POST: begin
        res_d = err_q ? '0 : post;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; strobes are high for the cycle spent in their state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      cx_q <= '0;
      cr_q <= '0;
      res_q <= '0;
      sl_q <= '0;
      sr_q <= '0;
      err_q <= 1'b0;
      cs_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      cx_q <= cx_d;
      cr_q <= cr_d;
      res_q <= res_d;
      sl_q <= sl_d;
      sr_q <= sr_d;
      err_q <= err_d;
      cs_q <= state_d == CORE_START;
      done_q <= state_d == DONE;
    end
  end
  assign busy_o = state_q != IDLE;
  assign core_x_o = cx_q;
  assign core_start_o = cs_q;
  assign result_o = res_q;
  assign shift_l_o = sl_q;
  assign shift_r_o = sr_q;
  assign err_o = err_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_approx_ctrl.sv
// tb_approx_ctrl: directed checks of approx_ctrl normalisation, core handshake, post-shift and reset abort
module tb_approx_ctrl;
  logic clk = 0, rst = 1, start_i = 0, core_done_i = 0;
  logic [15:0] x_i = '0, core_result_i = '0;
  logic busy_o, core_start_o, err_o, done_o;
  logic [15:0] core_x_o, result_o;
  logic [2:0] shift_l_o, shift_r_o;
  int checks = 0, errors = 0;
  int lat, ns, nd, cx, bad, cnt;

  approx_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .x_i(x_i), .busy_o(busy_o),
    .core_x_o(core_x_o), .core_start_o(core_start_o), .core_result_i(core_result_i),
    .core_done_i(core_done_i), .result_o(result_o), .shift_l_o(shift_l_o),
    .shift_r_o(shift_r_o), .err_o(err_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one transaction; the core answers c+1 cycles after core_start_o is seen
  task automatic run(input int x, input int cres, input int c, input bit hold,
                     output int lat_o, output int ns_o, output int nd_o, output int cx_o, output int bad_o);
    int ts;
    ts = -1; lat_o = -1; ns_o = 0; nd_o = 0; cx_o = -1; bad_o = 0;
    @(posedge clk); #1;
    x_i = 16'(x); core_result_i = 16'(cres); start_i = 1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (!hold) start_i = 0;
      core_done_i = 0;
      if (core_start_o) begin
        ns_o++;
        if (ts < 0) begin ts = i; cx_o = int'($signed(core_x_o)); end
      end
      if (ts >= 0 && i == ts + c + 1) core_done_i = 1;
      if (ts >= 0 && int'($signed(core_x_o)) != cx_o) bad_o++;
      if (lat_o < 0 && !busy_o) bad_o++;
      if (done_o) begin
        nd_o++;
        if (lat_o < 0) lat_o = i;
        start_i = 0;
      end
      if (lat_o >= 0 && i >= lat_o + 3) break;
    end
    start_i = 0;
    core_done_i = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_result", result_o, 0);
    check("rst_core_x", core_x_o, 0);
    check("rst_flags", {core_start_o, done_o, err_o, shift_l_o, shift_r_o}, 0);
    rst = 0;

    run(16384, 16384, 1, 0, lat, ns, nd, cx, bad);
    check("unit_lat", lat, 6);
    check("unit_cx", cx, 16384);
    check("unit_result", int'($signed(result_o)), 16384);
    check("unit_shifts", {shift_l_o, shift_r_o, 1'b0, err_o}, 0);
    check("unit_pulses", ns * 10 + nd, 11);
    check("unit_stable", bad, 0);

    run(32000, 16768, 1, 0, lat, ns, nd, cx, bad);
    check("r1_lat", lat, 7);
    check("r1_cx", cx, 16000);
    check("r1_sr", shift_r_o, 1);
    check("r1_sl", shift_l_o, 0);
    check("r1_result", int'($signed(result_o)), 8384);
    check("r1_err", err_o, 0);

    run(32000, -1000, 1, 0, lat, ns, nd, cx, bad);
    check("r1neg_result", int'($signed(result_o)), -500);

    run(8192, 16384, 1, 0, lat, ns, nd, cx, bad);
    check("l1_cx", cx, 16384);
    check("l1_sl", shift_l_o, 1);
`ifdef APPROX_CTRL_SAT_EN
    check("l1_result_sat", int'($signed(result_o)), 32767);
`else
    check("l1_result_wrap", int'($signed(result_o)), -32768);
`endif

    run(0, 16384, 1, 0, lat, ns, nd, cx, bad);
    check("zero_err", err_o, 1);
    check("zero_result", result_o, 0);
    check("zero_nostart", ns, 0);
    check("zero_done", nd * 100 + lat, 103);

    run(32000, 16768, 1, 0, lat, ns, nd, cx, bad);
    run(-5, 16384, 1, 0, lat, ns, nd, cx, bad);
    check("neg_err", err_o, 1);
    check("neg_result", result_o, 0);
    check("neg_nostart", ns, 0);
    check("neg_done", nd * 100 + lat, 103);

    run(1, 16384, 1, 0, lat, ns, nd, cx, bad);
    check("one_sl", shift_l_o, 7);
    check("one_err", err_o, 1);
    check("one_nostart", ns, 0);
    check("one_lat", lat, 10);

    run(16384, 12000, 20, 1, lat, ns, nd, cx, bad);
    check("slow_lat", lat, 25);
    check("slow_starts", ns, 1);
    check("slow_dones", nd, 1);
    check("slow_busy_stable", bad, 0);
    check("slow_result", int'($signed(result_o)), 12000);

    @(posedge clk); #1;
    x_i = 16384; core_result_i = 16384; start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    @(posedge clk); #1;
    check("abort_core_start", core_start_o, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; core_done_i = 1; core_result_i = 999;
    check("abort_busy", busy_o, 0);
    check("abort_result", result_o, 0);
    check("abort_core_x", core_x_o, 0);
    check("abort_flags", {core_start_o, done_o, err_o, shift_l_o, shift_r_o}, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      core_done_i = 0;
      cnt += int'(done_o) + int'(busy_o) + int'(core_start_o);
    end
    check("abort_quiet", cnt, 0);
    check("abort_result_held", result_o, 0);

    run(16384, 16384, 1, 0, lat, ns, nd, cx, bad);
    check("post_abort_lat", lat, 6);
    check("post_abort_result", int'($signed(result_o)), 16384);
    check("post_abort_pulses", ns * 10 + nd, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
